// File: rtl/clk_div_ctrl.sv
// CE/CLR sequencer for one BUFGCE_DIV divider: START/STOP/RESTART commands over valid/ready.
// Optional restart counter output (restart_cnt_o) is built when CLK_DIV_CTRL_CNT_EN is defined.
module clk_div_ctrl #(
  parameter int DIV         = 2,
  parameter int CLR_CYCLES  = 4,
  parameter int SETTLE_DIVS = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // Handshake: a command transfers on a clk_i edge where cmd_valid_i && cmd_ready_o;
  // the master holds cmd_valid_i/cmd_op_i stable until that edge.
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  output logic        bufg_ce_o,
  output logic        bufg_clr_o,
  output logic        div_clk_ready_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [2:0]  dbg_state_o
`ifdef CLK_DIV_CTRL_CNT_EN
  ,
  output logic [15:0] restart_cnt_o
`endif
);

  localparam int SETTLE_CYC = SETTLE_DIVS * DIV;
  localparam int MAX_A      = (CLR_CYCLES > SETTLE_DIVS * 8) ? CLR_CYCLES : SETTLE_DIVS * 8;
  localparam int MAX_B      = (MAX_A > 8) ? MAX_A : 8;
  localparam int CW         = $clog2(MAX_B + 1);

  localparam logic [CW-1:0] L_CLR = CW'(CLR_CYCLES);
  localparam logic [CW-1:0] L_SET = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] L_STP = CW'(DIV);

  localparam logic [1:0] OP_START   = 2'b01;
  localparam logic [1:0] OP_STOP    = 2'b10;
  localparam logic [1:0] OP_RESTART = 2'b11;

  if (DIV < 1 || DIV > 8) begin : g_bad_div
    $error("clk_div_ctrl: DIV must be in 1..8");
  end
  if (CLR_CYCLES < 1) begin : g_bad_clr
    $error("clk_div_ctrl: CLR_CYCLES must be >= 1");
  end
  if (SETTLE_DIVS < 1) begin : g_bad_settle
    $error("clk_div_ctrl: SETTLE_DIVS must be >= 1");
  end

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_CLEAR    = 3'd1,
    S_SETTLE   = 3'd2,
    S_RUN      = 3'd3,
    S_STOPPING = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ce, r_clr, r_rdy, r_busy, r_cmd_ready, r_err, r_restart;
  logic          w_accept, w_cnt_last, w_enter_clear;

  // Output pattern {ce, clr, ready, busy, cmd_ready} for each state.
  function automatic logic [4:0] outs(state_t s);
    case (s)
      S_OFF:      outs = 5'b01001;
      S_CLEAR:    outs = 5'b01010;
      S_SETTLE:   outs = 5'b10010;
      S_RUN:      outs = 5'b10101;
      S_STOPPING: outs = 5'b00010;
      default:    outs = 5'b01001;
    endcase
  endfunction

  assign w_accept      = cmd_valid_i && r_cmd_ready;
  assign w_cnt_last    = (r_cnt == CW'(1));
  assign w_enter_clear = ((r_state == S_OFF) && w_accept &&
                          ((cmd_op_i == OP_START) || (cmd_op_i == OP_RESTART))) ||
                         ((r_state == S_STOPPING) && w_cnt_last && r_restart);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_OFF;
      r_cnt       <= '0;
      r_ce        <= 1'b0;
      r_clr       <= 1'b1;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_err       <= 1'b0;
      r_restart   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_OFF: begin
          if (w_enter_clear) begin
            r_state <= S_CLEAR;
            r_cnt   <= L_CLR;
            {r_ce, r_clr, r_rdy, r_busy, r_cmd_ready} <= outs(S_CLEAR);
          end else if (w_accept && cmd_op_i == OP_STOP) begin
            r_err <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (w_cnt_last) begin
            r_state <= S_SETTLE;
            r_cnt   <= L_SET;
            {r_ce, r_clr, r_rdy, r_busy, r_cmd_ready} <= outs(S_SETTLE);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_SETTLE: begin
          if (w_cnt_last) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            {r_ce, r_clr, r_rdy, r_busy, r_cmd_ready} <= outs(S_RUN);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RUN: begin
          if (w_accept && (cmd_op_i == OP_STOP || cmd_op_i == OP_RESTART)) begin
            r_state   <= S_STOPPING;
            r_cnt     <= L_STP;
            r_restart <= (cmd_op_i == OP_RESTART);
            {r_ce, r_clr, r_rdy, r_busy, r_cmd_ready} <= outs(S_STOPPING);
          end else if (w_accept && cmd_op_i == OP_START) begin
            r_err <= 1'b1;
          end
        end
        S_STOPPING: begin
          // CE stays low for DIV source cycles so the divided period in flight completes.
          if (w_enter_clear) begin
            r_state <= S_CLEAR;
            r_cnt   <= L_CLR;
            {r_ce, r_clr, r_rdy, r_busy, r_cmd_ready} <= outs(S_CLEAR);
          end else if (w_cnt_last) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            {r_ce, r_clr, r_rdy, r_busy, r_cmd_ready} <= outs(S_OFF);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_OFF;
          r_cnt   <= '0;
          {r_ce, r_clr, r_rdy, r_busy, r_cmd_ready} <= outs(S_OFF);
        end
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [15:0] r_restart_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_restart_cnt <= '0;
    end else if (w_enter_clear && r_restart_cnt != 16'hFFFF) begin
      r_restart_cnt <= r_restart_cnt + 16'd1;
    end
  end
  assign restart_cnt_o = r_restart_cnt;
`endif

  assign cmd_ready_o     = r_cmd_ready;
  assign bufg_ce_o       = r_ce;
  assign bufg_clr_o      = r_clr;
  assign div_clk_ready_o = r_rdy;
  assign busy_o          = r_busy;
  assign err_o           = r_err;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed table-driven bench for clk_div_ctrl (DIV=2, CLR_CYCLES=4, SETTLE_DIVS=2).
// Restart counter checks are compiled in when CLK_DIV_CTRL_CNT_EN is defined.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i;
  logic [1:0] cmd_op_i;
  logic       cmd_ready_o, bufg_ce_o, bufg_clr_o, div_clk_ready_o, busy_o, err_o;
  logic [2:0] dbg_state_o;
`ifdef CLK_DIV_CTRL_CNT_EN
  logic [15:0] restart_cnt_o;
`endif

  always #5 clk = ~clk;

  clk_div_ctrl #(.DIV(2), .CLR_CYCLES(4), .SETTLE_DIVS(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_op_i        (cmd_op_i),
    .bufg_ce_o       (bufg_ce_o),
    .bufg_clr_o      (bufg_clr_o),
    .div_clk_ready_o (div_clk_ready_o),
    .busy_o          (busy_o),
    .err_o           (err_o),
    .dbg_state_o     (dbg_state_o)
`ifdef CLK_DIV_CTRL_CNT_EN
    ,
    .restart_cnt_o   (restart_cnt_o)
`endif
  );

  // Expected word: {ce, clr, ready, busy, cmd_ready, err, state[2:0]}
  localparam logic [8:0] E_OFF = 9'b01001_0_000;
  localparam logic [8:0] E_CLR = 9'b01010_0_001;
  localparam logic [8:0] E_SET = 9'b10010_0_010;
  localparam logic [8:0] E_RUN = 9'b10101_0_011;
  localparam logic [8:0] E_STP = 9'b00010_0_100;
  localparam logic [8:0] E_ERR = 9'b00000_1_000;

  localparam logic [1:0] NOP = 2'b00, START = 2'b01, STOP = 2'b10, RESTART = 2'b11;

  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic [8:0] exp;
  } vec_t;

  vec_t        vec_q[$];
  logic [8:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_clear_entries = 0;

  function automatic logic [8:0] act_word();
    return {bufg_ce_o, bufg_clr_o, div_clk_ready_o, busy_o, cmd_ready_o, err_o, dbg_state_o};
  endfunction

  // Clock/reset block helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver: queue n rows of the same input and expected output
  task automatic add(input int n, input logic v, input logic [1:0] op, input logic [8:0] e);
    vec_t r;
    for (int i = 0; i < n; i++) begin
      r.valid = v;
      r.op    = op;
      r.exp   = e;
      vec_q.push_back(r);
    end
  endtask

  // START from OFF through to the first RUN cycle, with optional held command
  task automatic add_start(input logic v, input logic [1:0] op);
    add(1, 1'b1, START, E_CLR);
    add(3, v, op, E_CLR);
    add(4, v, op, E_SET);
    add(1, v, op, E_RUN);
  endtask

  function automatic logic [8:0] start_model(input int c);
    if (c <= 4)      return E_CLR;
    else if (c <= 8) return E_SET;
    else             return E_RUN;
  endfunction

  initial begin
    logic [8:0] prev;
    string      nm;

    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_op_i    = NOP;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("reset_c%0d", i), 32'(act_word()), 32'(E_OFF));
    end
    rst_i = 1'b0;
`ifdef CLK_DIV_CTRL_CNT_EN
    check("cnt_after_reset", 32'(restart_cnt_o), 32'd0);
`endif

    add(2, 1'b0, NOP, E_OFF);                // idle hold
    add(1, 1'b1, NOP, E_OFF);                // NOP accepted, no effect
    add(2, 1'b1, STOP, E_OFF | E_ERR);       // back-to-back illegal STOP in OFF
    add(1, 1'b0, NOP, E_OFF);
    add_start(1'b0, NOP);                    // START timing
    add(1, 1'b0, NOP, E_RUN);
    add(1, 1'b1, START, E_RUN | E_ERR);      // START in RUN is illegal
    add(1, 1'b0, NOP, E_RUN);
    add(1, 1'b1, STOP, E_STP);               // STOP from RUN
    add(1, 1'b0, NOP, E_STP);
    add(2, 1'b0, NOP, E_OFF);
    add_start(1'b1, STOP);                   // STOP held while busy, taken in RUN
    add(1, 1'b1, STOP, E_STP);
    add(1, 1'b0, NOP, E_STP);
    add(1, 1'b0, NOP, E_OFF);
    add_start(1'b0, NOP);
    add(1, 1'b1, RESTART, E_STP);            // RESTART from RUN
    add(1, 1'b0, NOP, E_STP);
    add(4, 1'b0, NOP, E_CLR);
    add(4, 1'b0, NOP, E_SET);
    add(2, 1'b0, NOP, E_RUN);

    prev = E_OFF;
    foreach (vec_q[i]) begin
      exp_q.push_back(vec_q[i].exp);
      if (vec_q[i].exp[2:0] == 3'd1 && prev[2:0] != 3'd1) exp_clear_entries++;
      prev = vec_q[i].exp;
    end

    for (int i = 0; i < vec_q.size(); i++) begin
      cmd_valid_i = vec_q[i].valid;
      cmd_op_i    = vec_q[i].op;
      cyc();
      nm = $sformatf("row%0d", i);
      check(nm, 32'(act_word()), 32'(exp_q.pop_front()));
    end
    cmd_valid_i = 1'b0;
    cmd_op_i    = NOP;
`ifdef CLK_DIV_CTRL_CNT_EN
    check("cnt_after_table", 32'(restart_cnt_o), 32'(exp_clear_entries));
`endif

    // Return to OFF, then reset in the middle of SETTLE
    cmd_valid_i = 1'b1; cmd_op_i = STOP;
    cyc();
    cmd_valid_i = 1'b0; cmd_op_i = NOP;
    cyc(); cyc();
    check("back_to_off", 32'(act_word()), 32'(E_OFF));
    cmd_valid_i = 1'b1; cmd_op_i = START;
    cyc();                                     // now in cycle 1
    cmd_valid_i = 1'b0; cmd_op_i = NOP;
    for (int c = 2; c <= 6; c++) cyc();
    check("pre_reset_settle", 32'(act_word()), 32'(E_SET));
    rst_i = 1'b1;
    cyc();
    check("mid_settle_reset", 32'(act_word()), 32'(E_OFF));
    rst_i = 1'b0;
`ifdef CLK_DIV_CTRL_CNT_EN
    check("cnt_cleared", 32'(restart_cnt_o), 32'd0);
`endif

    // START after reset must repeat the original timing
    cmd_valid_i = 1'b1; cmd_op_i = START;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      cmd_valid_i = 1'b0; cmd_op_i = NOP;
      check($sformatf("restart_timing_c%0d", c), 32'(act_word()), 32'(start_model(c)));
    end
`ifdef CLK_DIV_CTRL_CNT_EN
    check("cnt_one_start", 32'(restart_cnt_o), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
